ascon_block_sequencer: RTL

- USB-domain scheduler that queues AD and plaintext blocks written by host registers and streams them into the Ascon core with the core's start/valid/last/EOT/select protocol.
- Handles multi-block AD and messages, captures ciphertext blocks and the tag, and reports status back to the register file.
- Sits between the register block and the Ascon core, replacing the fixed single-block AD/MSG sequencing.
- Core-side CDC is handled by an external shim, so all core signals here are in the usb_clk_buf domain.

---
 rtl/ascon_seq_pkg.sv | 34 +++
 rtl/ascon_blk_fifo.sv | 58 +++++
 rtl/ascon_block_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ascon_seq_pkg.sv
// Shared definitions for the Ascon block sequencer: FSM states, error codes
// and the bit layout of a queued block entry {last, vbytes, data}.
package ascon_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_AD_FEED,
    S_MSG_FEED,
    S_WAIT_TAG,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_NO_MSG   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int unsigned Q_DATA_LSB = 0;

  function automatic int unsigned q_vb_lsb(int unsigned blk_w);
    return blk_w;
  endfunction

  function automatic int unsigned q_last_bit(int unsigned blk_w, int unsigned vb_w);
    return blk_w + vb_w;
  endfunction

  function automatic int unsigned q_width(int unsigned blk_w, int unsigned vb_w);
    return blk_w + vb_w + 1;
  endfunction

endpackage

// File: rtl/ascon_blk_fifo.sv
// Synchronous block FIFO with occupancy level; pushes on a full queue are dropped
// and flush takes priority over push and pop.
module ascon_blk_fifo #(
  parameter int unsigned pDEPTH = 4,
  parameter int unsigned pWIDTH = 134
) (
  input  logic                      usb_clk_buf,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [pWIDTH-1:0]         din,
  output logic [pWIDTH-1:0]         dout,
  output logic [$clog2(pDEPTH):0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned LW = AW + 1;

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(pDEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge usb_clk_buf or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge usb_clk_buf) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ascon_block_sequencer.sv
// Queues host-written AD/MSG blocks and streams them into the Ascon core,
// capturing ciphertext and tag and reporting status to the register file.
module ascon_block_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int unsigned pDEPTH   = 4,
  parameter int unsigned pBLK_W   = 128,
  parameter int unsigned pVB_W    = 5,
  parameter int unsigned pTIMEOUT = 1024
) (
  input  logic                    usb_clk_buf,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic                    wr_type,
  input  logic [pBLK_W-1:0]       wr_data,
  input  logic [pVB_W-1:0]        wr_vbytes,
  input  logic                    wr_last,
  input  logic                    cmd_start,
  input  logic                    cmd_abort,
  output logic                    core_start,
  output logic [pBLK_W-1:0]       core_data,
  output logic [pVB_W-1:0]        core_vbytes,
  output logic                    core_valid,
  output logic                    core_last,
  output logic                    core_eot,
  output logic                    core_select,
  input  logic                    core_read_data,
  input  logic                    core_ct_valid,
  input  logic [pBLK_W-1:0]       core_ct,
  input  logic                    core_tag_ready,
  input  logic [pBLK_W-1:0]       core_tag,
  output logic [pBLK_W-1:0]       ct_out,
  output logic                    ct_out_valid,
  output logic [pBLK_W-1:0]       tag_out,
  output logic [$clog2(pDEPTH):0] ad_level,
  output logic [$clog2(pDEPTH):0] msg_level,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int unsigned QW       = q_width(pBLK_W, pVB_W);
  localparam int unsigned VB_LSB   = q_vb_lsb(pBLK_W);
  localparam int unsigned LAST_BIT = q_last_bit(pBLK_W, pVB_W);
  localparam int unsigned CW       = $clog2(pTIMEOUT);

  seq_state_t       state_q, state_d;
  logic [QW-1:0]    wr_entry, ad_head, msg_head, head;
  logic             ad_push, msg_push, ad_pop, msg_pop;
  logic             ad_full, ad_empty, msg_full, msg_empty;
  logic             feeding, pop_now, tmo_hit, head_ok, valid_d;
  logic [CW-1:0]    tmo_cnt;

  assign wr_entry = {wr_last, wr_vbytes, wr_data};
  assign ad_push  = wr_en && !wr_type;
  assign msg_push = wr_en && wr_type;
  assign feeding  = (state_q == S_AD_FEED) || (state_q == S_MSG_FEED);
  assign pop_now  = feeding && core_valid && core_read_data;
  assign ad_pop   = pop_now && (state_q == S_AD_FEED);
  assign msg_pop  = pop_now && (state_q == S_MSG_FEED);
  assign tmo_hit  = (tmo_cnt == CW'(pTIMEOUT - 1));
  assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});

  ascon_blk_fifo #(.pDEPTH(pDEPTH), .pWIDTH(QW)) u_ad_fifo (
    .usb_clk_buf (usb_clk_buf), .resetn (resetn), .flush (cmd_abort),
    .push (ad_push), .pop (ad_pop), .din (wr_entry), .dout (ad_head),
    .level (ad_level), .full (ad_full), .empty (ad_empty)
  );

  ascon_blk_fifo #(.pDEPTH(pDEPTH), .pWIDTH(QW)) u_msg_fifo (
    .usb_clk_buf (usb_clk_buf), .resetn (resetn), .flush (cmd_abort),
    .push (msg_push), .pop (msg_pop), .din (wr_entry), .dout (msg_head),
    .level (msg_level), .full (msg_full), .empty (msg_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (cmd_start) state_d = msg_empty ? S_ERR : S_START;
      S_START:    state_d = (!ad_empty || ad_push) ? S_AD_FEED : S_MSG_FEED;
      S_AD_FEED: begin
        if (pop_now) begin
          if (core_last) state_d = S_MSG_FEED;
        end else if (core_valid && tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_MSG_FEED: begin
        if (pop_now) begin
          if (core_last) state_d = S_WAIT_TAG;
        end else if (core_valid && tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_TAG: begin
        if (core_tag_ready)  state_d = S_DONE;
        else if (tmo_hit)    state_d = S_ERR;
      end
      S_DONE:     if (!core_tag_ready) state_d = S_IDLE;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_IDLE;
    endcase
    if (cmd_abort) state_d = S_IDLE;
  end

  // A block is only re-presented after the cycle following a pop, so the core
  // never sees the stale head while the registered outputs catch up.
  always_comb begin
    head    = (state_q == S_MSG_FEED) ? msg_head : ad_head;
    head_ok = (state_q == S_MSG_FEED) ? !msg_empty : !ad_empty;
    valid_d = feeding && (state_d == state_q) && !core_read_data && head_ok;
  end

  always_ff @(posedge usb_clk_buf or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || core_read_data)
        tmo_cnt <= '0;
      else if ((feeding && core_valid) || (state_q == S_WAIT_TAG))
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge usb_clk_buf or negedge resetn) begin
    if (!resetn) begin
      core_start   <= 1'b0;
      core_valid   <= 1'b0;
      core_data    <= '0;
      core_vbytes  <= '0;
      core_last    <= 1'b0;
      core_select  <= 1'b0;
      core_eot     <= 1'b0;
      ct_out       <= '0;
      ct_out_valid <= 1'b0;
      tag_out      <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      core_start   <= (state_d == S_START);
      core_valid   <= valid_d;
      core_data    <= valid_d ? head[Q_DATA_LSB +: pBLK_W] : '0;
      core_vbytes  <= valid_d ? head[VB_LSB +: pVB_W] : '0;
      core_last    <= valid_d && head[LAST_BIT];
      core_select  <= valid_d && (state_q == S_MSG_FEED);
      core_eot     <= valid_d && (state_q == S_MSG_FEED) && head[LAST_BIT];
      ct_out_valid <= core_ct_valid;
      if (core_ct_valid) ct_out <= core_ct;

      if (cmd_abort) begin
        done <= 1'b0;
      end else if ((state_q == S_WAIT_TAG) && core_tag_ready) begin
        done    <= 1'b1;
        tag_out <= core_tag;
      end else if ((state_q == S_IDLE) && (state_d == S_START)) begin
        done <= 1'b0;
      end

      if (cmd_abort) begin
        error    <= 1'b0;
        err_code <= ERR_NONE;
      end else if ((state_d == S_ERR) && (state_q != S_ERR)) begin
        error    <= 1'b1;
        err_code <= (state_q == S_IDLE) ? ERR_NO_MSG : ERR_TIMEOUT;
      end else if (wr_en && (wr_type ? msg_full : ad_full)) begin
        error    <= 1'b1;
        err_code <= ERR_OVERFLOW;
      end
    end
  end

endmodule
